// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock first-word-fall-through sample FIFO with flags and sticky errors

module sample_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    // Address width of the storage and pointer width including the wrap bit.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          rd_load;
    logic          wr_load;
    logic          mem_we;
    logic [PW-1:0] occupancy;

    // Status is derived purely from the registered pointers, so no rd/wr path reaches the flags.
    always_comb begin
        occupancy    = wr_ptr_q - rd_ptr_q;
        empty        = (rd_ptr_q == wr_ptr_q);
        full         = (rd_ptr_q[PW-1] != wr_ptr_q[PW-1]) &&
                       (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
        count        = occupancy;
        almost_empty = (int'(occupancy) <= AEMPTY_THR);
        almost_full  = (int'(occupancy) >= AFULL_THR);
        overflow     = overflow_q;
        underflow    = underflow_q;
        dout         = mem[rd_ptr_q[AW-1:0]];
    end

    // Accept decisions; a write into a full FIFO only goes through when a pop frees the slot.
    always_comb begin
        rd_load = rd && !empty;
        wr_load = wr && (!full || rd);
        mem_we  = wr_load && !reset && !flush;
    end

    // Next-state for pointers and sticky error flags; flush behaves like a functional reset.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (rd_load) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (wr_load) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (wr && !wr_load) begin
                overflow_d = 1'b1;
            end
            if (rd && !rd_load) begin
                underflow_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule
